alu_writeback_stage: RTL and testbench
======================================

// Module: alu_writeback_stage
// PURPOSE
//  Sits directly downstream of the 16-bit ALU: captures result, flags {Z,N,V,C} and op code.
//  Holds the architectural condition-code register (CCR) and evaluates branch conditions.
//  Buffers results to register-file writeback through a 2-entry skid buffer (valid/ready).
//  Provides a forwarding tap to the operand stage.
// PARAMETERS
//  DATA_W      16  result/writeback width (matches ALU bus width)
//  REG_ADDR_W  3   destination register address width
// PORTS
//  clk        in   1           clock, all state on rising edge
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           ALU result valid this cycle
//  in_ready   out  1           stage can accept; registered, = !skid_full
//  in_result  in   DATA_W      ALU busOut
//  in_flags   in   4           ALU flags {Z,N,V,C}
//  in_op      in   3           ALU control code used for this result
//  in_rd      in   REG_ADDR_W  destination register
//  in_wen     in   1           result is written to register file
//  in_setcc   in   1           instruction updates CCR
//  wb_valid   out  1           writeback entry available
//  wb_ready   in   1           register file consumes entry
//  wb_data    out  DATA_W      writeback data
//  wb_addr    out  REG_ADDR_W  writeback register
//  wb_en      out  1           writeback enable of head entry
//  ccr        out  4           condition codes {Z,N,V,C}
//  cond       in   4           branch condition selector
//  cond_true  out  1           selected condition holds
//  fwd_valid  out  1           = wb_valid & wb_en
//  fwd_addr   out  REG_ADDR_W  = wb_addr
//  fwd_data   out  DATA_W      = wb_data
// BEHAVIOUR
//  Reset: both entries empty, wb_valid=0, in_ready=1, ccr=4'b0000; wb_data/addr/en=0.
//  Accept: in_valid & in_ready.
//  Head: head empty (or being popped) -> accepted entry goes to head.
//        Otherwise -> accepted entry goes to skid.
//  Pop: wb_valid & wb_ready. Skid moves to head on pop; FIFO order always preserved.
//  Latency: accept in cycle N -> wb_valid high in N+1 when head was free.
//  Throughput: 1/cycle while wb_ready=1.
//  Stall: in_ready falls one cycle after skid fills and rises the cycle after skid drains.
//        Skid never overwritten.
//  Simultaneous accept+pop with full head, empty skid: head <= new entry, skid stays empty.
//  wb outputs stable while wb_valid & !wb_ready.
//  CCR update (at accept, in program order, independent of writeback stall):
//    in_setcc=0 or in_op in {000,111}: no change.
//    op 001/010 (add/sub): ccr <= in_flags.
//    op 011..110 (logic/shift): Z,N <= in_flags[3:2]; V,C hold.
//  cond_true is combinational from ccr:
//    0 AL=1   1 EQ=Z   2 NE=!Z   3 LT=N^V   4 GE=!(N^V)
//    5 CS=C   6 CC=!C  7 MI=N    8 PL=!N    9 VS=V   10 VC=!V
//    11 GT=!Z&!(N^V)   12 LE=Z|(N^V)   13-15 NV=0
//  rst mid-stream: buffered entries dropped, CCR cleared next edge; accept ignored that cycle.
// CONFIGURATION
//  CCR_BYPASS_EN defined:
//    cond_true evaluates the CCR value being written this cycle (post-update)
//    when an accept with in_setcc occurs, so a branch right after a compare resolves with 0 bubble.
//  Undefined:
//    cond_true uses registered ccr only; result visible one cycle after accept.
// TESTING
//  1 Reset: rst=1 two cycles -> wb_valid=0, in_ready=1, ccr=0, cond=0 gives 1, cond=1 gives 0.
//  2 Stream, wb_ready=1: accept 0x0015 rd=2 wen=1 -> next cycle wb_data=0x0015, wb_addr=2, fwd_valid=1.
//  3 Stall: wb_ready=0, push A,B -> in_ready=0. Raise wb_ready -> pops A then B, no loss or dup.
//  4 CCR: sub op=010 flags 4'b0011 setcc -> ccr=0011, LT=0 since N^V=1? no: N=0,V=1 -> LT=1, VS=1.
//     Then xor op=101 flags 4'b1000 -> ccr=1011, EQ=1.
//  5 setcc=0 and op=000 with flags 4'b1111 -> ccr unchanged.
//  6 CCR_BYPASS_EN: accept add flags 4'b1000 setcc, cond=1 same cycle -> cond_true=1.
//     Without macro -> 0, then 1 next cycle.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: captures ALU results into a 2-entry skid buffer that feeds
// register-file writeback. It also holds the condition-code register (CCR),
// evaluates branch conditions, and drives a forwarding tap from the head entry.
// Latency and backpressure:
//   - An accept in cycle N shows up on wb_* in cycle N+1 when the head is free.
//   - in_ready is !skid_full. The skid entry is never overwritten.
// Optional feature: define CCR_BYPASS_EN so that cond_true sees the CCR value
// being written in the current cycle.
// Ports:
//   clk, rst                              clock and synchronous active-high reset
//   in_valid/in_ready                     ALU result handshake
//   in_result/in_flags/in_op/in_rd/in_wen/in_setcc   ALU result payload
//   wb_valid/wb_ready                     writeback handshake
//   wb_data/wb_addr/wb_en                 head entry
//   ccr                                   condition codes {Z,N,V,C}
//   cond -> cond_true                     branch condition evaluation
//   fwd_valid/fwd_addr/fwd_data           forwarding tap (mirrors the head entry)
module alu_writeback_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_result,
    input  logic [3:0]            in_flags,
    input  logic [2:0]            in_op,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wen,
    input  logic                  in_setcc,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_W-1:0]     wb_data,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic                  wb_en,
    output logic [3:0]            ccr,
    input  logic [3:0]            cond,
    output logic                  cond_true,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]     fwd_data
);

    // Head entry: the one presented to writeback.
    logic                  r_head_vld;
    logic [DATA_W-1:0]     r_head_data;
    logic [REG_ADDR_W-1:0] r_head_addr;
    logic                  r_head_en;

    // Skid entry: only ever filled while the head is occupied and not popping.
    logic                  r_skid_vld;
    logic [DATA_W-1:0]     r_skid_data;
    logic [REG_ADDR_W-1:0] r_skid_addr;
    logic                  r_skid_en;

    logic [3:0]            r_ccr;

    logic                  w_accept;
    logic                  w_pop;
    logic [3:0]            w_ccr_next;
    logic [3:0]            w_cond_src;

    // An accept is ignored during a reset cycle.
    assign w_accept = in_valid & in_ready & ~rst;
    assign w_pop    = r_head_vld & wb_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_vld  <= 1'b0;
            r_head_data <= '0;
            r_head_addr <= '0;
            r_head_en   <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_skid_addr <= '0;
            r_skid_en   <= 1'b0;
        end else if (w_pop) begin
            if (r_skid_vld) begin
                // When the skid is full, in_ready is low, so no accept can
                // happen this cycle. The skid simply advances into the head.
                r_head_data <= r_skid_data;
                r_head_addr <= r_skid_addr;
                r_head_en   <= r_skid_en;
                r_skid_vld  <= 1'b0;
            end else if (w_accept) begin
                // Pop and accept in the same cycle: the new entry replaces the
                // head, and the skid stays empty.
                r_head_data <= in_result;
                r_head_addr <= in_rd;
                r_head_en   <= in_wen;
            end else begin
                r_head_vld  <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_head_vld) begin
                r_head_vld  <= 1'b1;
                r_head_data <= in_result;
                r_head_addr <= in_rd;
                r_head_en   <= in_wen;
            end else begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= in_result;
                r_skid_addr <= in_rd;
                r_skid_en   <= in_wen;
            end
        end
    end

    // The CCR is updated in program order at accept time, regardless of
    // whether writeback is stalled.
    always_comb begin
        w_ccr_next = r_ccr;
        if (w_accept && in_setcc) begin
            case (in_op)
                3'b001, 3'b010:                 w_ccr_next = in_flags;
                3'b011, 3'b100, 3'b101, 3'b110: w_ccr_next = {in_flags[3:2], r_ccr[1:0]};
                default:                        w_ccr_next = r_ccr;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ccr <= 4'b0000;
        end else begin
            r_ccr <= w_ccr_next;
        end
    end

    function automatic logic f_cond(input logic [3:0] c, input logic [3:0] sel);
        logic z, n, v, cy;
        logic r;
        z  = c[3];
        n  = c[2];
        v  = c[1];
        cy = c[0];
        case (sel)
            4'd0:    r = 1'b1;
            4'd1:    r = z;
            4'd2:    r = ~z;
            4'd3:    r = n ^ v;
            4'd4:    r = ~(n ^ v);
            4'd5:    r = cy;
            4'd6:    r = ~cy;
            4'd7:    r = n;
            4'd8:    r = ~n;
            4'd9:    r = v;
            4'd10:   r = ~v;
            4'd11:   r = ~z & ~(n ^ v);
            4'd12:   r = z | (n ^ v);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

`ifdef CCR_BYPASS_EN
    // Evaluate the post-update value, so a branch directly after a compare
    // resolves with no bubble.
    assign w_cond_src = w_ccr_next;
`else
    assign w_cond_src = r_ccr;
`endif

    assign cond_true = f_cond(w_cond_src, cond);

    assign in_ready  = ~r_skid_vld;
    assign wb_valid  = r_head_vld;
    assign wb_data   = r_head_data;
    assign wb_addr   = r_head_addr;
    assign wb_en     = r_head_en;
    assign ccr       = r_ccr;
    assign fwd_valid = r_head_vld & r_head_en;
    assign fwd_addr  = r_head_addr;
    assign fwd_data  = r_head_data;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed testbench for alu_writeback_stage. Inputs change on the falling
// edge, and outputs are sampled on the falling edge or shortly after it.
module tb_alu_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_flags;
    logic [2:0]  in_op;
    logic [2:0]  in_rd;
    logic        in_wen;
    logic        in_setcc;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [2:0]  wb_addr;
    logic        wb_en;
    logic [3:0]  ccr;
    logic [3:0]  cond;
    logic        cond_true;
    logic        fwd_valid;
    logic [2:0]  fwd_addr;
    logic [15:0] fwd_data;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_writeback_stage #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_flags(in_flags), .in_op(in_op), .in_rd(in_rd), .in_wen(in_wen),
        .in_setcc(in_setcc),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_addr(wb_addr), .wb_en(wb_en),
        .ccr(ccr), .cond(cond), .cond_true(cond_true),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one ALU result. The caller advances time.
    task automatic drive(input logic [15:0] res, input logic [2:0] rd, input logic wen,
                         input logic [2:0] op, input logic [3:0] fl, input logic sc);
        in_valid  = 1'b1;
        in_result = res;
        in_rd     = rd;
        in_wen    = wen;
        in_op     = op;
        in_flags  = fl;
        in_setcc  = sc;
    endtask

    task automatic cond_chk(input string tag, input logic [3:0] sel, input logic exp);
        cond = sel;
        #1;
        chk(tag, {31'd0, cond_true}, {31'd0, exp});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0; in_op = '0;
        in_rd = '0; in_wen = 1'b0; in_setcc = 1'b0; wb_ready = 1'b0; cond = 4'd0;

        // 1: reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_ccr", {28'd0, ccr}, 32'd0);
        chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
        cond_chk("rst_cond_al", 4'd0, 1'b1);
        cond_chk("rst_cond_eq", 4'd1, 1'b0);

        // 2: streaming with wb_ready high
        wb_ready = 1'b1;
        @(negedge clk);
        drive(16'h0015, 3'd2, 1'b1, 3'b000, 4'b0000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("s_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("s_wb_data", {16'd0, wb_data}, 32'h0015);
        chk("s_wb_addr", {29'd0, wb_addr}, 32'd2);
        chk("s_fwd_valid", {31'd0, fwd_valid}, 32'd1);
        chk("s_fwd_data", {16'd0, fwd_data}, 32'h0015);
        @(negedge clk);
        chk("s_drained", {31'd0, wb_valid}, 32'd0);

        // Back-to-back entries: 1 per cycle, and the head is replaced during a pop.
        drive(16'h1111, 3'd1, 1'b1, 3'b000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("b2b_0", {16'd0, wb_data}, 32'h1111);
        drive(16'h2222, 3'd5, 1'b1, 3'b000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("b2b_1", {16'd0, wb_data}, 32'h2222);
        chk("b2b_1_addr", {29'd0, wb_addr}, 32'd5);
        chk("b2b_rdy", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drained", {31'd0, wb_valid}, 32'd0);

        // 3: stall fills the skid, then the buffer drains in order
        wb_ready = 1'b0;
        drive(16'hA0A0, 3'd3, 1'b1, 3'b000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("st_a_head", {16'd0, wb_data}, 32'hA0A0);
        chk("st_rdy_1", {31'd0, in_ready}, 32'd1);
        drive(16'hB0B0, 3'd4, 1'b0, 3'b000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("st_rdy_0", {31'd0, in_ready}, 32'd0);
        chk("st_hold_a", {16'd0, wb_data}, 32'hA0A0);
        drive(16'hC0C0, 3'd6, 1'b1, 3'b000, 4'b0000, 1'b0);  // must be ignored
        @(negedge clk);
        in_valid = 1'b0;
        chk("st_still_a", {16'd0, wb_data}, 32'hA0A0);
        chk("st_still_a_addr", {29'd0, wb_addr}, 32'd3);
        wb_ready = 1'b1;
        @(negedge clk);
        chk("st_pop_b", {16'd0, wb_data}, 32'hB0B0);
        chk("st_pop_b_addr", {29'd0, wb_addr}, 32'd4);
        chk("st_b_fwd", {31'd0, fwd_valid}, 32'd0);
        chk("st_rdy_back", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("st_no_dup", {31'd0, wb_valid}, 32'd0);

        // 4: CCR from sub, then logic ops
        drive(16'h0000, 3'd0, 1'b0, 3'b010, 4'b0011, 1'b1);
        cond = 4'd3;
        #1;
`ifdef CCR_BYPASS_EN
        chk("sub_lt_same", {31'd0, cond_true}, 32'd1);
`else
        chk("sub_lt_same", {31'd0, cond_true}, 32'd0);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        chk("sub_ccr", {28'd0, ccr}, 32'b0011);
        cond_chk("sub_lt", 4'd3, 1'b1);
        cond_chk("sub_vs", 4'd9, 1'b1);
        cond_chk("sub_ge", 4'd4, 1'b0);
        cond_chk("sub_le", 4'd12, 1'b1);
        cond_chk("sub_gt", 4'd11, 1'b0);
        drive(16'h0000, 3'd0, 1'b0, 3'b101, 4'b1000, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("xor_ccr", {28'd0, ccr}, 32'b1011);
        cond_chk("xor_eq", 4'd1, 1'b1);
        cond_chk("xor_ne", 4'd2, 1'b0);
        cond_chk("xor_cs", 4'd5, 1'b1);
        cond_chk("xor_mi", 4'd7, 1'b0);

        // 5: no-update cases
        drive(16'h0000, 3'd0, 1'b0, 3'b010, 4'b1111, 1'b0);
        @(negedge clk);
        drive(16'h0000, 3'd0, 1'b0, 3'b000, 4'b1111, 1'b1);
        @(negedge clk);
        drive(16'h0000, 3'd0, 1'b0, 3'b111, 4'b1111, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("noupd_ccr", {28'd0, ccr}, 32'b1011);
        // Shift op: Z,N taken from flags, V,C held.
        drive(16'h0000, 3'd0, 1'b0, 3'b110, 4'b0100, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("shf_ccr", {28'd0, ccr}, 32'b0111);
        cond_chk("shf_mi", 4'd7, 1'b1);
        cond_chk("shf_nv", 4'd13, 1'b0);
        cond_chk("shf_vc", 4'd10, 1'b0);

        // 6: zero-bubble branch when the bypass is enabled
        drive(16'h0000, 3'd0, 1'b0, 3'b001, 4'b1000, 1'b1);
        cond = 4'd1;
        #1;
`ifdef CCR_BYPASS_EN
        chk("byp_eq_same", {31'd0, cond_true}, 32'd1);
`else
        chk("byp_eq_same", {31'd0, cond_true}, 32'd0);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        cond_chk("byp_eq_next", 4'd1, 1'b1);
        chk("add_ccr", {28'd0, ccr}, 32'b1000);

        // Reset in the middle of a stalled stream
        wb_ready = 1'b0;
        drive(16'hD0D0, 3'd1, 1'b1, 3'b000, 4'b0000, 1'b0);
        @(negedge clk);
        drive(16'hE0E0, 3'd2, 1'b1, 3'b000, 4'b0000, 1'b0);
        @(negedge clk);
        chk("mr_full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        drive(16'hF0F0, 3'd7, 1'b1, 3'b001, 4'b1111, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mr_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mr_ccr", {28'd0, ccr}, 32'd0);
        chk("mr_wb_data", {16'd0, wb_data}, 32'd0);
        @(negedge clk);
        chk("mr_ignored", {31'd0, wb_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
